// File: rtl/fft_pkg.sv
// Shared FFT types: sample format, reorder bank states and the bit-reversal helper.
package fft_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned MAX_LOG2N  = 12;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] re;
        logic [DATA_WIDTH-1:0] im;
    } complex_t;

    typedef enum logic [1:0] {
        BankEmpty,
        BankFilling,
        BankFull,
        BankDraining
    } bank_state_t;

    // Reverses the low 'width' bits of idx; upper bits come back zero.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] idx,
                                                    input int unsigned width);
        logic [MAX_LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < width; i++) begin
            r[i] = idx[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_out_reorder_ram.sv
// Simple dual-port RAM holding both reorder banks; synchronous read with read enable so the
// read data holds while the output pipeline is stalled.
module reorder_ram #(
    parameter int unsigned AW = 5,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_out_reorder.sv
// Bit-reversed to natural-order FFT output reorder buffer (ping-pong banks, valid/ready out).
// Optional sticky drop flag port ovf is built when FFT_REORDER_OVF_EN is defined.
module fft_out_reorder
    import fft_pkg::*;
#(
    parameter int unsigned LOG2N = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  complex_t din,
    input  logic     din_valid,
    output complex_t dout,
    output logic     dout_valid,
    input  logic     dout_ready,
    output logic     dout_last
`ifdef FFT_REORDER_OVF_EN
    ,
    output logic     ovf
`endif
);

    localparam int unsigned N       = 2 ** LOG2N;
    localparam int unsigned AW      = LOG2N + 1;
    localparam logic [LOG2N-1:0] LastIdx = LOG2N'(N - 1);

    bank_state_t      bank_q [2];
    bank_state_t      bank_d [2];
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic             wb_q, wb_d;
    logic             drop_q, drop_d;
    // ib: bank being read from RAM; rb: bank of the sample currently at the output.
    logic             ib_q, ib_d;
    logic             rb_q, rb_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;

    logic             s1_valid_q, s1_last_q;
    complex_t         dout_q;
    logic             dout_valid_q, dout_last_q;

    logic             frame_start, start_ok, ram_we;
    logic [LOG2N-1:0] wrev;
    logic             out_free, rd_avail, issue, xfer_last;
    logic [2*DATA_WIDTH-1:0] ram_rdata;

    assign frame_start = din_valid && (wcnt_q == '0);
    assign start_ok    = (bank_q[wb_q] == BankEmpty);
    assign ram_we      = din_valid && (frame_start ? start_ok : !drop_q);
    assign wrev        = LOG2N'(bitrev(MAX_LOG2N'(wcnt_q), LOG2N));

    assign out_free  = !dout_valid_q || dout_ready;
    assign rd_avail  = (bank_q[ib_q] == BankFull) || (bank_q[ib_q] == BankDraining);
    assign issue     = rd_avail && (!s1_valid_q || out_free);
    assign xfer_last = dout_valid_q && dout_ready && dout_last_q;

    reorder_ram #(
        .AW(AW),
        .DW(2 * DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr ({wb_q, wrev}),
        .wdata (din),
        .re    (issue),
        .raddr ({ib_q, rd_cnt_q}),
        .rdata (ram_rdata)
    );

    always_comb begin
        bank_d   = bank_q;
        wcnt_d   = wcnt_q;
        wb_d     = wb_q;
        drop_d   = drop_q;
        ib_d     = ib_q;
        rb_d     = rb_q;
        rd_cnt_d = rd_cnt_q;

        if (din_valid) begin
            wcnt_d = wcnt_q + 1'b1;
            if (frame_start) begin
                if (start_ok) begin
                    bank_d[wb_q] = BankFilling;
                end else begin
                    drop_d = 1'b1;
                end
            end
            if (wcnt_q == LastIdx) begin
                if (drop_q) begin
                    drop_d = 1'b0;
                end else begin
                    bank_d[wb_q] = BankFull;
                    wb_d         = ~wb_q;
                end
            end
        end

        // The read side moves on to the other bank as soon as its last address is issued.
        if (issue) begin
            bank_d[ib_q] = BankDraining;
            rd_cnt_d     = rd_cnt_q + 1'b1;
            if (rd_cnt_q == LastIdx) begin
                ib_d = ~ib_q;
            end
        end

        if (xfer_last) begin
            bank_d[rb_q] = BankEmpty;
            rb_d         = ~rb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= BankEmpty;
            bank_q[1] <= BankEmpty;
            wcnt_q    <= '0;
            wb_q      <= 1'b0;
            drop_q    <= 1'b0;
            ib_q      <= 1'b0;
            rb_q      <= 1'b0;
            rd_cnt_q  <= '0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            wcnt_q    <= wcnt_d;
            wb_q      <= wb_d;
            drop_q    <= drop_d;
            ib_q      <= ib_d;
            rb_q      <= rb_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            if (issue) begin
                s1_valid_q <= 1'b1;
                s1_last_q  <= (rd_cnt_q == LastIdx);
            end else if (s1_valid_q && out_free) begin
                s1_valid_q <= 1'b0;
            end
            if (out_free) begin
                dout_valid_q <= s1_valid_q;
                dout_last_q  <= s1_valid_q && s1_last_q;
                if (s1_valid_q) begin
                    dout_q <= complex_t'(ram_rdata);
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;

`ifdef FFT_REORDER_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (frame_start && !start_ok) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: directed tables plus a randomized frame-level model.
module tb_fft_out_reorder;
    import fft_pkg::*;

    localparam int N = 16;

    typedef struct packed {
        complex_t d;
        logic     last;
    } samp_t;

    typedef struct {
        int unsigned nat;
        int unsigned exp_re;
        logic        exp_last;
    } vec_t;

    logic     clk;
    logic     rst;
    complex_t din;
    logic     din_valid;
    complex_t dout;
    logic     dout_valid;
    logic     dout_ready;
    logic     dout_last;
`ifdef FFT_REORDER_OVF_EN
    logic     ovf;
`endif

    fft_out_reorder #(
        .LOG2N(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last)
`ifdef FFT_REORDER_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Frame-level reference: frames go in as written samples, come out reindexed by bit reversal.
    samp_t    expq[$];
    complex_t frame_buf[N];
    int       wk = 0;
    logic     dropping = 1'b0;
    int       accepted = 0;
    int       drained  = 0;

    samp_t got_q[$];
    int    last_pos[$];
    int    n_xfer = 0;
    int    cyc = 0;
    int    first_valid_cyc = -1;
    int    first_xfer_cyc = -1;
    int    last_xfer_cyc = -1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int tb_rev(input int x);
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            if (((x >> i) & 1) != 0) r |= 1 << (3 - i);
        end
        return r;
    endfunction

    function automatic complex_t mk(input int re, input int im);
        complex_t c;
        c.re = 16'(re);
        c.im = 16'(im);
        return c;
    endfunction

    task automatic cycle(input logic v, input complex_t d, input logic rdy, input logic r);
        samp_t    e;
        logic     stall;
        complex_t pd;
        logic     pl;
        logic     drain_now;
        din_valid  = v;
        din        = d;
        dout_ready = rdy;
        rst        = r;
        drain_now  = 1'b0;
        if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (!r && dout_valid && rdy) begin
            got_q.push_back(samp_t'({dout, dout_last}));
            if (n_xfer == 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            n_xfer++;
            if (dout_last) last_pos.push_back(n_xfer);
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_xfer: actual=%0h required=no transfer (cycle %0d)",
                         dout, cyc);
            end else begin
                e = expq.pop_front();
                chk("xfer_data", dout, e.d);
                chk("xfer_last", 32'(dout_last), 32'(e.last));
                drain_now = e.last;
            end
        end
        if (r) begin
            expq.delete();
            wk       = 0;
            dropping = 1'b0;
            accepted = 0;
            drained  = 0;
        end else if (v) begin
            if (wk == 0) begin
                dropping = (accepted - drained) >= 2;
                if (!dropping) accepted++;
            end
            if (!dropping) frame_buf[wk] = d;
            if (wk == N - 1) begin
                if (!dropping) begin
                    for (int j = 0; j < N; j++) begin
                        expq.push_back(samp_t'({frame_buf[tb_rev(j)], j == N - 1}));
                    end
                end
                wk = 0;
            end else begin
                wk++;
            end
        end
        stall = !r && dout_valid && !rdy;
        pd    = dout;
        pl    = dout_last;
        @(posedge clk);
        #1;
        cyc++;
        if (drain_now) drained++;
        if (stall) begin
            chk("stall_data", dout, pd);
            chk("stall_last", 32'(dout_last), 32'(pl));
        end
        if (r) begin
            chk("rst_valid", 32'(dout_valid), 32'd0);
            chk("rst_last", 32'(dout_last), 32'd0);
            chk("rst_dout", dout, 32'd0);
`ifdef FFT_REORDER_OVF_EN
            chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        end
    endtask

    task automatic clear_log();
        got_q.delete();
        last_pos.delete();
        n_xfer          = 0;
        first_valid_cyc = -1;
        first_xfer_cyc  = -1;
        last_xfer_cyc   = -1;
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        clear_log();
    endtask

    task automatic idle_until(input int want, input int budget);
        for (int i = 0; i < budget && n_xfer < want; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[N];
        int unsigned rev_list[N];
        int          t_last;

        rev_list = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        for (int i = 0; i < N; i++) begin
            tbl[i].nat      = i;
            tbl[i].exp_re   = rev_list[i];
            tbl[i].exp_last = (i == N - 1);
        end
        din = '0;
        din_valid = 1'b0;
        dout_ready = 1'b1;
        rst = 1'b1;

        // Single frame: order, last marker, latency.
        do_reset();
        t_last = 0;
        for (int k = 0; k < N; k++) begin
            if (k == N - 1) t_last = cyc;
            cycle(1'b1, mk(k, 100 + k), 1'b1, 1'b0);
        end
        idle_until(N, 40);
        chk("t1_count", n_xfer, N);
        chk("t1_latency", first_valid_cyc, t_last + 3);
        for (int i = 0; i < N; i++) begin
            if (i < got_q.size()) begin
                chk("t1_re", 32'(got_q[i].d.re), tbl[i].exp_re);
                chk("t1_im", 32'(got_q[i].d.im), 100 + tbl[i].exp_re);
                chk("t1_last", 32'(got_q[i].last), 32'(tbl[i].exp_last));
            end
        end

        // Two back-to-back frames: 32 contiguous transfers.
        do_reset();
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N; k++) cycle(1'b1, mk(k, 100 * (f + 1) + k), 1'b1, 1'b0);
        end
        idle_until(2 * N, 60);
        chk("t2_count", n_xfer, 2 * N);
        chk("t2_contig", last_xfer_cyc - first_xfer_cyc, 2 * N - 1);
        chk("t2_nlast", last_pos.size(), 2);
        if (last_pos.size() == 2) begin
            chk("t2_last0", last_pos[0], N);
            chk("t2_last1", last_pos[1], 2 * N);
        end

        // Overflow: ready low, three frames, third dropped.
        do_reset();
        for (int f = 0; f < 3; f++) begin
`ifdef FFT_REORDER_OVF_EN
            if (f == 2) chk("t3_ovf_before", 32'(ovf), 32'd0);
`endif
            for (int k = 0; k < N; k++) cycle(1'b1, mk(k, 100 * (f + 1) + k), 1'b0, 1'b0);
        end
        cycle(1'b0, '0, 1'b0, 1'b0);
        chk("t3_held", n_xfer, 0);
        chk("t3_valid", 32'(dout_valid), 32'd1);
`ifdef FFT_REORDER_OVF_EN
        chk("t3_ovf", 32'(ovf), 32'd1);
`endif
        idle_until(2 * N, 100);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t3_count", n_xfer, 2 * N);
        chk("t3_model_empty", expq.size(), 0);
        if (got_q.size() == 2 * N) begin
            chk("t3_f1_first", 32'(got_q[0].d.im), 100);
            chk("t3_f2_first", 32'(got_q[N].d.im), 200);
        end
`ifdef FFT_REORDER_OVF_EN
        chk("t3_ovf_sticky", 32'(ovf), 32'd1);
`endif

        // Reset at sample 7 of a frame while the previous frame drains.
        do_reset();
        for (int k = 0; k < N; k++) cycle(1'b1, mk(k, 100 + k), 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) cycle(1'b1, mk(k, 200 + k), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        clear_log();
        for (int k = 0; k < N; k++) cycle(1'b1, mk(k, 300 + k), 1'b1, 1'b0);
        idle_until(N, 40);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t4_count", n_xfer, N);
        chk("t4_model_empty", expq.size(), 0);
        if (got_q.size() > 0) chk("t4_first_im", 32'(got_q[0].d.im), 300);

        // Random din gaps and random ready over 100 frames.
        do_reset();
        for (int f = 0; f < 100; f++) begin
            for (int k = 0; k < N; ) begin
                logic v;
                v = ($urandom_range(0, 3) != 0);
                cycle(v, mk($urandom_range(0, 65535), $urandom_range(0, 65535)),
                      1'($urandom_range(0, 1)), 1'b0);
                if (v) k++;
            end
        end
        for (int i = 0; i < 300 && expq.size() > 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t5_model_empty", expq.size(), 0);
        chk("t5_frames", last_pos.size(), accepted);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
